// File: rtl/md_sequencer_if.sv
// Handshake/result bundle between the E-stage issue logic and the multiply/divide sequencer.
interface md_sequencer_if;
    logic        en;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        err;

    modport master (output en, op, A, B, input busy, HI, LO, err);
    modport slave  (input en, op, A, B, output busy, HI, LO, err);
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair.
// Define MD_SEQUENCER_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops (7-10).
//
// state | meaning
// IDLE  | accepts launches and MTHI/MTLO
// RUN   | counter running; result written when it reaches zero
module md_sequencer (
    input  logic          clk,
    input  logic          reset,
    md_sequencer_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_SEQUENCER_MADD_EN
    localparam logic [3:0] OP_MAX   = 4'd10;
`else
    localparam logic [3:0] OP_MAX   = 4'd6;
`endif

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q, hi_q, lo_q;
    logic        err_q;

    logic        is_mul, is_div, reserved;
    logic        launch, done, mt_hi, mt_lo, err_nxt;
    logic [3:0]  n_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (launch) state_nxt = RUN;
            RUN:  if (done)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        is_mul   = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                   ((bus.op >= 4'd7) && (bus.op <= OP_MAX));
        is_div   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        reserved = (bus.op > OP_MAX);
        n_load   = is_div ? 4'd10 : 4'd5;
        launch   = (state == IDLE) && bus.en && (is_mul || is_div);
        mt_hi    = (state == IDLE) && bus.en && (bus.op == OP_MTHI);
        mt_lo    = (state == IDLE) && bus.en && (bus.op == OP_MTLO);
        done     = (state == RUN) && (cnt == 4'd1);
        err_nxt  = bus.en && (bus.op != 4'd0) && ((state == RUN) || reserved);
    end

    // One shared multiplier and one shared divider; signedness folded into the operands.
    logic        mul_signed, div_signed;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] div_a, div_b, q_raw, r_raw, quot, rem;
    logic [63:0] res;
    logic        res_we;

    always_comb begin
        mul_signed = (op_q == OP_MULT) || (op_q == 4'd7) || (op_q == 4'd9);
        mul_a      = {{32{mul_signed & a_q[31]}}, a_q};
        mul_b      = {{32{mul_signed & b_q[31]}}, b_q};
        prod       = mul_a * mul_b;

        div_signed = (op_q == OP_DIV);
        div_a      = (div_signed && a_q[31]) ? -a_q : a_q;
        div_b      = (div_signed && b_q[31]) ? -b_q : b_q;
        q_raw      = div_a / div_b;
        r_raw      = div_a % div_b;
        quot       = (div_signed && (a_q[31] ^ b_q[31])) ? -q_raw : q_raw;
        rem        = (div_signed && a_q[31]) ? -r_raw : r_raw;

        res    = 64'd0;
        res_we = 1'b0;
        case (op_q)
            OP_MULT, OP_MULTU: begin res = prod;        res_we = 1'b1;            end
            OP_DIV, OP_DIVU:   begin res = {rem, quot}; res_we = (b_q != 32'd0);  end
`ifdef MD_SEQUENCER_MADD_EN
            4'd7, 4'd8:        begin res = {hi_q, lo_q} + prod; res_we = 1'b1;   end
            4'd9, 4'd10:       begin res = {hi_q, lo_q} - prod; res_we = 1'b1;   end
`endif
            default:           begin res = 64'd0;       res_we = 1'b0;            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 4'd0;
            op_q  <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_nxt;
            if (launch) begin
                cnt  <= n_load;
                op_q <= bus.op;
                a_q  <= bus.A;
                b_q  <= bus.B;
            end else if (state == RUN) begin
                cnt <= cnt - 4'd1;
            end
            if (done && res_we) {hi_q, lo_q} <= res;
            if (mt_hi) hi_q <= bus.A;
            if (mt_lo) lo_q <= bus.A;
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.err  = err_q;
endmodule
